// File: rtl/pong_ball.sv
// Pong ball engine: serve/play/point/game-over sequencing, ball motion with wall
// and paddle bounces, miss detection and saturating scores. All outputs registered.
module pong_ball #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int LEFT_X     = 20,
  parameter int RIGHT_X    = 620,
  parameter int PAD_HALF_H = 50,
  parameter int PAD_HALF_W = 5,
  parameter int BALL_HALF  = 4,
  parameter int SPEED_X    = 4,
  parameter int SPEED_Y    = 2,
  parameter int HOLD_TICKS = 60,
  parameter int WIN_SCORE  = 5
) (
  input  logic       clk,
  input  logic       rst_d,
  input  logic       tick,
  input  logic       serve,
  input  logic [9:0] left_y,
  input  logic [9:0] right_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       either_win,
  output logic       left_win,
  output logic       right_win,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_POINT = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic signed [10:0] C_BH     = 11'(BALL_HALF);
  localparam logic signed [10:0] C_SX     = 11'(SPEED_X);
  localparam logic signed [10:0] C_SY     = 11'(SPEED_Y);
  localparam logic signed [10:0] C_LX_IN  = 11'(LEFT_X + PAD_HALF_W);
  localparam logic signed [10:0] C_LX_OUT = 11'(LEFT_X - PAD_HALF_W);
  localparam logic signed [10:0] C_RX_IN  = 11'(RIGHT_X - PAD_HALF_W);
  localparam logic signed [10:0] C_RX_OUT = 11'(RIGHT_X + PAD_HALF_W);
  localparam logic signed [10:0] C_REACH  = 11'(PAD_HALF_H + BALL_HALF);
  localparam logic signed [10:0] C_XMAX   = 11'(SCREEN_W - 1 - BALL_HALF);
  localparam logic signed [10:0] C_YMAX   = 11'(SCREEN_H - 1 - BALL_HALF);

  localparam logic [9:0] C_CX     = 10'(SCREEN_W / 2);
  localparam logic [9:0] C_CY     = 10'(SCREEN_H / 2);
  localparam logic [9:0] C_LHIT_X = 10'(LEFT_X + PAD_HALF_W + BALL_HALF);
  localparam logic [9:0] C_RHIT_X = 10'(RIGHT_X - PAD_HALF_W - BALL_HALF);
  localparam logic [9:0] C_YLO    = 10'(BALL_HALF);
  localparam logic [9:0] C_YHI    = 10'(SCREEN_H - 1 - BALL_HALF);
  localparam logic [3:0] C_WIN    = 4'(WIN_SCORE);
  localparam logic [HW-1:0] C_HOLD_LAST = HW'(HOLD_TICKS - 1);

  state_t        r_state, w_state_nx;
  logic [9:0]    r_ball_x, r_ball_y, w_ball_x_nx, w_ball_y_nx;
  logic          r_dx_neg, r_dy_neg, w_dx_neg_nx, w_dy_neg_nx;
  logic [3:0]    r_left_score, r_right_score, w_left_score_nx, w_right_score_nx;
  logic          r_either_win, r_left_win, r_right_win;
  logic          w_either_win_nx, w_left_win_nx, w_right_win_nx;
  logic          r_serve_left, w_serve_left_nx;
  logic [HW-1:0] r_hold, w_hold_nx;
  logic          r_serve_q;

  logic                w_serve_edge;
  logic signed [10:0]  w_cx, w_cy, w_nx, w_ny, w_dl, w_dr, w_al, w_ar;
  logic                w_hit_l, w_hit_r, w_miss_l, w_miss_r;
  logic [3:0]          w_ls_inc, w_rs_inc;

  assign w_serve_edge = serve & ~r_serve_q;

  // Position math in 11-bit signed so steps past either edge compare correctly.
  assign w_cx = signed'({1'b0, r_ball_x});
  assign w_cy = signed'({1'b0, r_ball_y});
  assign w_nx = w_cx + (r_dx_neg ? -C_SX : C_SX);
  assign w_ny = w_cy + (r_dy_neg ? -C_SY : C_SY);
  assign w_dl = w_cy - signed'({1'b0, left_y});
  assign w_dr = w_cy - signed'({1'b0, right_y});
  assign w_al = w_dl[10] ? -w_dl : w_dl;
  assign w_ar = w_dr[10] ? -w_dr : w_dr;

  assign w_hit_l = r_dx_neg && (w_nx - C_BH <= C_LX_IN) && (w_cx - C_BH > C_LX_OUT) && (w_al < C_REACH);
  assign w_hit_r = !r_dx_neg && (w_nx + C_BH >= C_RX_IN) && (w_cx + C_BH < C_RX_OUT) && (w_ar < C_REACH);
  assign w_miss_l = (w_nx <= C_BH);
  assign w_miss_r = (w_nx >= C_XMAX);

  assign w_ls_inc = (r_left_score  == 4'd15) ? 4'd15 : r_left_score  + 4'd1;
  assign w_rs_inc = (r_right_score == 4'd15) ? 4'd15 : r_right_score + 4'd1;

  always_comb begin
    // NOTE: every next-value signal takes its current value first, so no path can infer a latch.
    w_state_nx       = r_state;
    w_ball_x_nx      = r_ball_x;
    w_ball_y_nx      = r_ball_y;
    w_dx_neg_nx      = r_dx_neg;
    w_dy_neg_nx      = r_dy_neg;
    w_left_score_nx  = r_left_score;
    w_right_score_nx = r_right_score;
    w_either_win_nx  = r_either_win;
    w_left_win_nx    = r_left_win;
    w_right_win_nx   = r_right_win;
    w_serve_left_nx  = r_serve_left;
    w_hold_nx        = r_hold;

    if (r_state != S_PLAY) begin
      w_ball_x_nx = C_CX;
      w_ball_y_nx = C_CY;
      w_dx_neg_nx = r_serve_left;
      w_dy_neg_nx = 1'b0;
    end

    unique case (r_state)
      S_IDLE: if (w_serve_edge) w_state_nx = S_PLAY;

      S_PLAY: if (tick) begin
        if (w_ny <= C_BH) begin
          w_ball_y_nx = C_YLO;
          w_dy_neg_nx = 1'b0;
        end else if (w_ny >= C_YMAX) begin
          w_ball_y_nx = C_YHI;
          w_dy_neg_nx = 1'b1;
        end else begin
          w_ball_y_nx = w_ny[9:0];
        end

        if (w_hit_l) begin
          w_ball_x_nx = C_LHIT_X;
          w_dx_neg_nx = 1'b0;
        end else if (w_hit_r) begin
          w_ball_x_nx = C_RHIT_X;
          w_dx_neg_nx = 1'b1;
        end else if (w_miss_l || w_miss_r) begin
          w_hold_nx       = '0;
          w_ball_x_nx     = C_CX;
          w_ball_y_nx     = C_CY;
          w_dy_neg_nx     = 1'b0;
          w_serve_left_nx = w_miss_l;
          w_dx_neg_nx     = w_miss_l;
          w_state_nx      = S_POINT;
          if (w_miss_l) begin
            w_right_score_nx = w_rs_inc;
            if (w_rs_inc == C_WIN) begin
              w_state_nx      = S_OVER;
              w_either_win_nx = 1'b1;
              w_right_win_nx  = 1'b1;
            end
          end else begin
            w_left_score_nx = w_ls_inc;
            if (w_ls_inc == C_WIN) begin
              w_state_nx      = S_OVER;
              w_either_win_nx = 1'b1;
              w_left_win_nx   = 1'b1;
            end
          end
        end else begin
          w_ball_x_nx = w_nx[9:0];
        end
      end

      S_POINT: if (tick) begin
        if (r_hold == C_HOLD_LAST) begin
          w_state_nx = S_PLAY;
          w_hold_nx  = '0;
        end else begin
          w_hold_nx = r_hold + HW'(1);
        end
      end

      S_OVER: if (w_serve_edge) begin
        w_state_nx       = S_IDLE;
        w_left_score_nx  = '0;
        w_right_score_nx = '0;
        w_either_win_nx  = 1'b0;
        w_left_win_nx    = 1'b0;
        w_right_win_nx   = 1'b0;
      end

      default: w_state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst_d) begin
    if (rst_d) begin
      r_state       <= S_IDLE;
      r_ball_x      <= C_CX;
      r_ball_y      <= C_CY;
      r_dx_neg      <= 1'b0;
      r_dy_neg      <= 1'b0;
      r_left_score  <= '0;
      r_right_score <= '0;
      r_either_win  <= 1'b0;
      r_left_win    <= 1'b0;
      r_right_win   <= 1'b0;
      r_serve_left  <= 1'b0;
      r_hold        <= '0;
      r_serve_q     <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_ball_x      <= w_ball_x_nx;
      r_ball_y      <= w_ball_y_nx;
      r_dx_neg      <= w_dx_neg_nx;
      r_dy_neg      <= w_dy_neg_nx;
      r_left_score  <= w_left_score_nx;
      r_right_score <= w_right_score_nx;
      r_either_win  <= w_either_win_nx;
      r_left_win    <= w_left_win_nx;
      r_right_win   <= w_right_win_nx;
      r_serve_left  <= w_serve_left_nx;
      r_hold        <= w_hold_nx;
      r_serve_q     <= serve;
    end
  end

  assign ball_x      = r_ball_x;
  assign ball_y      = r_ball_y;
  assign left_score  = r_left_score;
  assign right_score = r_right_score;
  assign either_win  = r_either_win;
  assign left_win    = r_left_win;
  assign right_win   = r_right_win;
  assign state       = r_state;

endmodule

// File: tb/tb_pong_ball.sv
// Directed bench for pong_ball: a behavioural game model feeds a scoreboard queue
// that is compared against the DUT after every clock.
module tb_pong_ball;

  logic       clk = 1'b0;
  logic       rst_d, tick, serve;
  logic [9:0] left_y, right_y;
  logic [9:0] ball_x, ball_y;
  logic [3:0] left_score, right_score;
  logic       either_win, left_win, right_win;
  logic [1:0] state;

  always #5 clk = ~clk;

  pong_ball dut (
    .clk(clk), .rst_d(rst_d), .tick(tick), .serve(serve),
    .left_y(left_y), .right_y(right_y),
    .ball_x(ball_x), .ball_y(ball_y),
    .left_score(left_score), .right_score(right_score),
    .either_win(either_win), .left_win(left_win), .right_win(right_win),
    .state(state)
  );

  typedef struct {
    int st, x, y, ls, rs, ew, lw, rw;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  int m_st, m_x, m_y, m_dxn, m_dyn, m_ls, m_rs, m_lw, m_rw, m_hold, m_srvl;
  int ev_l, ev_top;
  int l_mode, r_mode;
  bit serve_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_x = 320; m_y = 240; m_dxn = 0; m_dyn = 0;
    m_ls = 0; m_rs = 0; m_lw = 0; m_rw = 0; m_hold = 0; m_srvl = 0;
    serve_prev = 1'b0;
  endtask

  task automatic model_point();
    m_hold = 0; m_x = 320; m_y = 240; m_dyn = 0; m_dxn = m_srvl;
    if (m_ls == 5 || m_rs == 5) begin
      m_st = 3; m_lw = (m_ls == 5); m_rw = (m_rs == 5);
    end else begin
      m_st = 2;
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Paddle placement relative to the ball row: 0 tracks, 1 far away, 2 just out of reach.
  function automatic int paddle(input int mode);
    if (mode == 0) return m_y;
    if (mode == 1) return (m_y >= 240) ? m_y - 200 : m_y + 200;
    return m_y + 60;
  endfunction

  task automatic model_cycle(input bit t, input bit se, input int lp, input int rp);
    int nx, ny, cy;
    ev_l = 0; ev_top = 0;
    case (m_st)
      0: if (se) m_st = 1;
      1: if (t) begin
        cy = m_y;
        nx = m_x + (m_dxn != 0 ? -4 : 4);
        ny = m_y + (m_dyn != 0 ? -2 : 2);
        if (ny <= 4) begin m_y = 4; m_dyn = 0; ev_top = 1; end
        else if (ny >= 475) begin m_y = 475; m_dyn = 1; end
        else m_y = ny;
        if (m_dxn != 0 && nx - 4 <= 25 && m_x - 4 > 15 && iabs(cy - lp) < 54) begin
          m_x = 29; m_dxn = 0; ev_l = 1;
        end else if (m_dxn == 0 && nx + 4 >= 615 && m_x + 4 < 625 && iabs(cy - rp) < 54) begin
          m_x = 611; m_dxn = 1;
        end else if (nx <= 4) begin
          if (m_rs < 15) m_rs++;
          m_srvl = 1; model_point();
        end else if (nx >= 635) begin
          if (m_ls < 15) m_ls++;
          m_srvl = 0; model_point();
        end else begin
          m_x = nx;
        end
      end
      2: if (t) begin
        if (m_hold == 59) begin m_st = 1; m_hold = 0; end
        else m_hold++;
      end
      default: if (se) begin
        m_st = 0; m_ls = 0; m_rs = 0; m_lw = 0; m_rw = 0;
      end
    endcase
    if (m_st == 0 || m_st == 3) begin
      m_x = 320; m_y = 240; m_dxn = m_srvl; m_dyn = 0;
    end
  endtask

  task automatic do_cycle(input bit t, input bit s, input string tag);
    exp_t e, got;
    bit   se;
    left_y  = 10'(paddle(l_mode));
    right_y = 10'(paddle(r_mode));
    se = s && !serve_prev;
    serve_prev = s;
    model_cycle(t, se, int'(left_y), int'(right_y));
    e.st = m_st; e.x = m_x; e.y = m_y; e.ls = m_ls; e.rs = m_rs;
    e.ew = (m_st == 3) ? 1 : 0; e.lw = m_lw; e.rw = m_rw;
    sb.push_back(e);
    tick  = t;
    serve = s;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    got = sb.pop_front();
    check({tag, "_state"}, 32'(state), got.st);
    check({tag, "_x"}, 32'(ball_x), got.x);
    check({tag, "_y"}, 32'(ball_y), got.y);
    check({tag, "_lscore"}, 32'(left_score), got.ls);
    check({tag, "_rscore"}, 32'(right_score), got.rs);
    check({tag, "_either"}, 32'(either_win), got.ew);
    check({tag, "_lwin"}, 32'(left_win), got.lw);
    check({tag, "_rwin"}, 32'(right_win), got.rw);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_x"}, 32'(ball_x), 320);
    check({tag, "_y"}, 32'(ball_y), 240);
    check({tag, "_lscore"}, 32'(left_score), 0);
    check({tag, "_rscore"}, 32'(right_score), 0);
    check({tag, "_either"}, 32'(either_win), 0);
    check({tag, "_lwin"}, 32'(left_win), 0);
    check({tag, "_rwin"}, 32'(right_win), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_l, seen_top, pend6, pend33, found;

    rst_d = 1'b1; tick = 1'b0; serve = 1'b0;
    left_y = 10'd240; right_y = 10'd240;
    l_mode = 0; r_mode = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_d = 1'b0;

    do_cycle(0, 0, "idle_quiet");
    do_cycle(1, 0, "idle_tick");
    do_cycle(1, 1, "serve_with_tick");
    check("serve_with_tick_no_motion", 32'(ball_x), 320);
    do_cycle(1, 1, "first_tick");
    check("first_tick_x", 32'(ball_x), 324);
    check("first_tick_y", 32'(ball_y), 242);
    do_cycle(0, 0, "serve_release");
    do_cycle(0, 1, "serve_in_play");
    check("serve_in_play_ignored", 32'(state), 1);
    do_cycle(0, 0, "no_tick_hold");
    check("no_tick_hold_x", 32'(ball_x), 324);

    // Full rally with both paddles tracking until a left hit and a top-wall bounce are seen.
    seen_l = 0; seen_top = 0; pend6 = 0; pend33 = 0;
    for (int i = 0; i < 3000 && !(seen_l && seen_top && !pend6 && !pend33); i++) begin
      do_cycle(1, 0, "rally");
      if (pend6)  begin check("top_bounce_y", 32'(ball_y), 6); pend6 = 0; end
      if (pend33) begin check("lhit_bounce_x", 32'(ball_x), 33); pend33 = 0; end
      if (ev_top != 0) begin check("top_wall_y", 32'(ball_y), 4); seen_top = 1; pend6 = 1; end
      if (ev_l != 0)   begin check("lhit_x", 32'(ball_x), 29); seen_l = 1; pend33 = 1; end
    end
    check("rally_bound", 32'(seen_l && seen_top), 1);

    // Bring the ball back to x=31 heading left, then put the paddle just out of reach.
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_dxn != 0 && m_x == 31 && m_st == 1) found = 1;
      else do_cycle(1, 0, "approach");
    end
    check("approach_bound", 32'(found), 1);
    l_mode = 2;
    do_cycle(1, 0, "near_miss");
    check("near_miss_x", 32'(ball_x), 27);
    for (int i = 0; i < 50 && m_st == 1; i++) do_cycle(1, 0, "miss_run");
    check("miss_state", 32'(state), 2);
    check("miss_rscore", 32'(right_score), 1);
    check("miss_center_x", 32'(ball_x), 320);

    l_mode = 0;
    repeat (59) do_cycle(1, 0, "hold");
    check("hold_59", 32'(state), 2);
    do_cycle(0, 0, "hold_no_tick");
    do_cycle(1, 0, "hold_60");
    check("hold_60_state", 32'(state), 1);
    do_cycle(1, 0, "serve_left");
    check("serve_left_x", 32'(ball_x), 316);
    check("serve_left_y", 32'(ball_y), 242);

    // Right paddle stays away so the left side wins the match.
    r_mode = 1;
    for (int i = 0; i < 4000 && m_st != 3; i++) do_cycle(1, 0, "match");
    check("over_state", 32'(state), 3);
    check("over_lscore", 32'(left_score), 5);
    check("over_either", 32'(either_win), 1);
    check("over_lwin", 32'(left_win), 1);
    check("over_rwin", 32'(right_win), 0);
    do_cycle(1, 0, "over_tick");
    do_cycle(0, 1, "restart");
    check("restart_state", 32'(state), 0);
    check("restart_lscore", 32'(left_score), 0);
    check("restart_either", 32'(either_win), 0);
    do_cycle(0, 0, "restart_release");

    r_mode = 0;
    do_cycle(1, 1, "serve2");
    repeat (6) do_cycle(1, 0, "flight");
    check("flight_state", 32'(state), 1);
    #2;
    rst_d = 1'b1;
    #1;
    check_reset("async_reset");
    @(negedge clk);
    model_reset();
    rst_d = 1'b0;
    do_cycle(0, 0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
